// File: rtl/riscv_bus_pkg.sv
// Shared types for the fetch/data bus arbiter: master identity and the
// request field bundle presented to the slave port.
package riscv_bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } owner_e;

    typedef struct packed {
        logic                    we;
        logic [BUS_DATA_W/8-1:0] be;
        logic [BUS_ADDR_W-1:0]   addr;
        logic [BUS_DATA_W-1:0]   wdata;
    } bus_req_t;

    function automatic owner_e otherOwner(input owner_e owner);
        return (owner == OWNER_IF) ? OWNER_DM : OWNER_IF;
    endfunction

endpackage

// File: rtl/riscv_owner_fifo.sv
// Small in-order FIFO of owner IDs, one entry per granted-but-unanswered
// bus transaction. Any depth >= 1 is supported; pointers wrap at DEPTH.
module riscv_owner_fifo
    import riscv_bus_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  owner_e           pushOwner,
    input  logic             pop,
    output owner_e           headOwner,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    owner_e           mem [DEPTH];
    logic [DEPTH-1:0] wrEn;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop & ~empty;
    // A pop frees the slot this cycle, so a push into a full FIFO is legal then.
    assign doPush = push & (~full | doPop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wrEn[gi] = doPush & (wrPtr == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= OWNER_IF;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wrEn[i]) begin
                    mem[i] <= pushOwner;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (doPop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign headOwner = mem[rdPtr];

endmodule

// File: rtl/riscv_bus_arbiter.sv
// Shares one slave port between the fetch and data masters: per-request
// arbitration with a hold-until-granted lock, and in-order response routing.
module riscv_bus_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int DATA_PRIO       = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_dm_req,
    input  logic                i_dm_we,
    input  logic [DATA_W/8-1:0] i_dm_be,
    input  logic [ADDR_W-1:0]   i_dm_addr,
    input  logic [DATA_W-1:0]   i_dm_wdata,
    output logic                o_dm_gnt,
    output logic                o_dm_rvalid,
    output logic [DATA_W-1:0]   o_dm_rdata,
    output logic                o_bus_req,
    output logic                o_bus_we,
    output logic [DATA_W/8-1:0] o_bus_be,
    output logic [ADDR_W-1:0]   o_bus_addr,
    output logic [DATA_W-1:0]   o_bus_wdata,
    input  logic                i_bus_gnt,
    input  logic                i_bus_rvalid,
    input  logic [DATA_W-1:0]   i_bus_rdata,
    output logic                o_proto_err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    owner_e           selOwner;
    owner_e           lockOwnerReg;
    owner_e           lastOwnerReg;
    owner_e           headOwner;
    logic             lockReg;
    logic             errReg;
    logic             selReq;
    logic             busGrant;
    logic             respPop;
    logic [CNT_W-1:0] fifoCount;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             unusedFifoFull;

    assign unusedFifoFull = fifoFull;

    always_comb begin
        selOwner = OWNER_IF;
        if (lockReg) begin
            selOwner = lockOwnerReg;
        end else if (DATA_PRIO != 0) begin
            selOwner = i_dm_req ? OWNER_DM : OWNER_IF;
        end else if (i_dm_req && i_if_req) begin
            selOwner = otherOwner(lastOwnerReg);
        end else begin
            selOwner = i_dm_req ? OWNER_DM : OWNER_IF;
        end
    end

    assign selReq = (selOwner == OWNER_DM) ? i_dm_req : i_if_req;

    // Registered count only: a response popping this cycle does not reopen the port until next cycle.
    assign o_bus_req = selReq & (fifoCount < CNT_W'(MAX_OUTSTANDING)) & ~rst;
    assign busGrant  = o_bus_req & i_bus_gnt;
    assign o_if_gnt  = busGrant & (selOwner == OWNER_IF);
    assign o_dm_gnt  = busGrant & (selOwner == OWNER_DM);

    always_comb begin
        o_bus_we    = 1'b0;
        o_bus_be    = '1;
        o_bus_addr  = i_if_addr;
        o_bus_wdata = '0;
        if (selOwner == OWNER_DM) begin
            o_bus_we    = i_dm_we;
            o_bus_be    = i_dm_be;
            o_bus_addr  = i_dm_addr;
            o_bus_wdata = i_dm_wdata;
        end
    end

    assign respPop     = i_bus_rvalid & ~fifoEmpty & ~rst;
    assign o_if_rvalid = respPop & (headOwner == OWNER_IF);
    assign o_dm_rvalid = respPop & (headOwner == OWNER_DM);
    assign o_if_rdata  = i_bus_rdata;
    assign o_dm_rdata  = i_bus_rdata;
    assign o_proto_err = errReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lockReg      <= 1'b0;
            lockOwnerReg <= OWNER_IF;
            lastOwnerReg <= OWNER_IF;
            errReg       <= 1'b0;
        end else begin
            // A refused request pins the selection so its fields stay stable.
            if (o_bus_req && !i_bus_gnt) begin
                lockReg      <= 1'b1;
                lockOwnerReg <= selOwner;
            end else if (busGrant) begin
                lockReg <= 1'b0;
            end
            if (busGrant) begin
                lastOwnerReg <= selOwner;
            end
            if (i_bus_rvalid && fifoEmpty) begin
                errReg <= 1'b1;
            end
        end
    end

    riscv_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_owner_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (busGrant),
        .pushOwner (selOwner),
        .pop       (respPop),
        .headOwner (headOwner),
        .count     (fifoCount),
        .full      (fifoFull),
        .empty     (fifoEmpty)
    );

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// Directed and randomized checks of the bus arbiter in fixed-priority and
// round-robin configurations, against a queue-based reference model.
module tb_riscv_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        dmReq;
    logic        dmWe;
    logic [3:0]  dmBe;
    logic [31:0] dmAddr;
    logic [31:0] dmWdata;
    logic        busGnt;
    logic        busRvalid;
    logic [31:0] busRdata;

    logic        ifGntP, ifRvalidP, dmGntP, dmRvalidP, busReqP, busWeP, protoErrP;
    logic [31:0] ifRdataP, dmRdataP, busAddrP, busWdataP;
    logic [3:0]  busBeP;
    logic        ifGntR, ifRvalidR, dmGntR, dmRvalidR, busReqR, busWeR, protoErrR;
    logic [31:0] ifRdataR, dmRdataR, busAddrR, busWdataR;
    logic [3:0]  busBeR;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    riscv_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2), .DATA_PRIO(1)) dutP (
        .clk(clk), .rst(rst),
        .i_if_req(ifReq), .i_if_addr(ifAddr),
        .o_if_gnt(ifGntP), .o_if_rvalid(ifRvalidP), .o_if_rdata(ifRdataP),
        .i_dm_req(dmReq), .i_dm_we(dmWe), .i_dm_be(dmBe), .i_dm_addr(dmAddr), .i_dm_wdata(dmWdata),
        .o_dm_gnt(dmGntP), .o_dm_rvalid(dmRvalidP), .o_dm_rdata(dmRdataP),
        .o_bus_req(busReqP), .o_bus_we(busWeP), .o_bus_be(busBeP), .o_bus_addr(busAddrP),
        .o_bus_wdata(busWdataP), .i_bus_gnt(busGnt), .i_bus_rvalid(busRvalid),
        .i_bus_rdata(busRdata), .o_proto_err(protoErrP)
    );

    riscv_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2), .DATA_PRIO(0)) dutR (
        .clk(clk), .rst(rst),
        .i_if_req(ifReq), .i_if_addr(ifAddr),
        .o_if_gnt(ifGntR), .o_if_rvalid(ifRvalidR), .o_if_rdata(ifRdataR),
        .i_dm_req(dmReq), .i_dm_we(dmWe), .i_dm_be(dmBe), .i_dm_addr(dmAddr), .i_dm_wdata(dmWdata),
        .o_dm_gnt(dmGntR), .o_dm_rvalid(dmRvalidR), .o_dm_rdata(dmRdataR),
        .o_bus_req(busReqR), .o_bus_we(busWeR), .o_bus_be(busBeR), .o_bus_addr(busAddrR),
        .o_bus_wdata(busWdataR), .i_bus_gnt(busGnt), .i_bus_rvalid(busRvalid),
        .i_bus_rdata(busRdata), .o_proto_err(protoErrR)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setIdle();
        ifReq = 1'b0; ifAddr = '0;
        dmReq = 1'b0; dmWe = 1'b0; dmBe = '0; dmAddr = '0; dmWdata = '0;
        busGnt = 1'b0; busRvalid = 1'b0; busRdata = '0;
    endtask

    // Reference model state for the randomized phase (fixed-priority instance)
    bit          ownerQ[$];
    bit          waitValid, waitOwner;
    bit          pendIf, pendDm;
    bit          sel, expReq, expIfGnt, expDmGnt, expIfRv, expDmRv;

    initial begin
        rst = 1'b1;
        setIdle();

        // Reset: outputs stay quiet even with every input asserted
        @(negedge clk);
        ifReq = 1'b1; dmReq = 1'b1; busGnt = 1'b1; busRvalid = 1'b1;
        #2;
        chk1("rst_bus_req", busReqP, 1'b0);
        chk1("rst_if_gnt", ifGntP, 1'b0);
        chk1("rst_dm_gnt", dmGntP, 1'b0);
        chk1("rst_if_rvalid", ifRvalidP, 1'b0);
        chk1("rst_dm_rvalid", dmRvalidP, 1'b0);
        chk1("rst_proto_err", protoErrP, 1'b0);
        @(negedge clk);
        setIdle();
        rst = 1'b0;
        #2;
        chk1("idle_bus_req", busReqP, 1'b0);
        chk1("idle_if_gnt", ifGntP, 1'b0);
        chk1("idle_dm_rvalid", dmRvalidP, 1'b0);
        chk1("idle_proto_err", protoErrP, 1'b0);
        chk32("idle_bus_addr", busAddrP, 32'h0);
        $display("txn reset/idle checked");

        // Single fetch: granted same cycle, answered two cycles later
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 32'h100; busGnt = 1'b1;
        #2;
        chk1("if_single_req", busReqP, 1'b1);
        chk1("if_single_gnt", ifGntP, 1'b1);
        chk1("if_single_dm_gnt", dmGntP, 1'b0);
        chk32("if_single_addr", busAddrP, 32'h100);
        chk1("if_single_we", busWeP, 1'b0);
        chk32("if_single_be", {28'd0, busBeP}, 32'hF);
        @(negedge clk);
        setIdle();
        #2;
        chk1("if_single_gnt_once", ifGntP, 1'b0);
        @(negedge clk);
        busRvalid = 1'b1; busRdata = 32'hDEADBEEF;
        #2;
        chk1("if_single_rvalid", ifRvalidP, 1'b1);
        chk32("if_single_rdata", ifRdataP, 32'hDEADBEEF);
        chk1("if_single_dm_rvalid", dmRvalidP, 1'b0);
        $display("txn single fetch addr=0x100 rdata=0x%08h", ifRdataP);

        // Both masters at once: data first under fixed priority
        @(negedge clk);
        setIdle();
        ifReq = 1'b1; ifAddr = 32'h200;
        dmReq = 1'b1; dmAddr = 32'h300; dmWe = 1'b1; dmBe = 4'h3; dmWdata = 32'h55;
        busGnt = 1'b1;
        #2;
        chk1("prio_first_dm_gnt", dmGntP, 1'b1);
        chk1("prio_first_if_gnt", ifGntP, 1'b0);
        chk32("prio_first_addr", busAddrP, 32'h300);
        chk1("prio_first_we", busWeP, 1'b1);
        chk32("prio_first_wdata", busWdataP, 32'h55);
        chk1("rr_first_dm_gnt", dmGntR, 1'b1);
        @(negedge clk);
        dmReq = 1'b0;
        #2;
        chk1("prio_second_if_gnt", ifGntP, 1'b1);
        chk32("prio_second_addr", busAddrP, 32'h200);
        @(negedge clk);
        setIdle();
        busRvalid = 1'b1; busRdata = 32'h1;
        #2;
        chk1("prio_resp1_dm", dmRvalidP, 1'b1);
        chk1("prio_resp1_if", ifRvalidP, 1'b0);
        chk32("prio_resp1_data", dmRdataP, 32'h1);
        @(negedge clk);
        busRdata = 32'h2;
        #2;
        chk1("prio_resp2_if", ifRvalidP, 1'b1);
        chk1("prio_resp2_dm", dmRvalidP, 1'b0);
        chk32("prio_resp2_data", ifRdataP, 32'h2);
        $display("txn priority pair: dm then if, responses routed");

        // Round-robin alternation with a push and a pop in the same cycle
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            setIdle();
            ifReq = 1'b1; ifAddr = 32'h1000 + 32'(k);
            dmReq = 1'b1; dmAddr = 32'h2000 + 32'(k);
            busGnt = 1'b1;
            busRvalid = (k >= 1);
            busRdata = 32'(k);
            #2;
            chk1("rr_alt_dm_gnt", dmGntR, (k % 2) == 0);
            chk1("rr_alt_if_gnt", ifGntR, (k % 2) == 1);
            chk1("rr_alt_bus_req", busReqR, 1'b1);
            chk1("prio_cont_dm_gnt", dmGntP, 1'b1);
            if (k >= 1) begin
                chk1("rr_order_dm_rv", dmRvalidR, ((k - 1) % 2) == 0);
                chk1("rr_order_if_rv", ifRvalidR, ((k - 1) % 2) == 1);
            end
            $display("txn rr cycle %0d dm_gnt=%0b if_gnt=%0b", k, dmGntR, ifGntR);
        end
        @(negedge clk);
        setIdle();
        busRvalid = 1'b1;
        #2;
        chk1("rr_drain_if_rv", ifRvalidR, 1'b1);
        chk1("prio_drain_dm_rv", dmRvalidP, 1'b1);

        // Lock: slave stalls an IF request while DM arrives
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            setIdle();
            ifReq = (c < 4); ifAddr = 32'h400;
            dmReq = (c >= 2); dmAddr = 32'h500;
            busGnt = (c >= 3);
            #2;
            chk32("lock_addr", busAddrP, (c < 4) ? 32'h400 : 32'h500);
            chk1("lock_if_gnt", ifGntP, c == 3);
            chk1("lock_dm_gnt", dmGntP, c == 4);
            $display("txn lock cycle %0d addr=0x%08h", c, busAddrP);
        end
        @(negedge clk);
        setIdle();
        busRvalid = 1'b1;
        #2;
        chk1("lock_resp_if", ifRvalidP, 1'b1);
        @(negedge clk);
        #2;
        chk1("lock_resp_dm", dmRvalidP, 1'b1);

        // Outstanding limit of two, released only the cycle after a response
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            setIdle();
            ifReq = 1'b1; ifAddr = 32'h600 + 32'(4 * c);
            busGnt = (c != 3);
            busRvalid = (c == 3);
            #2;
            chk1("limit_bus_req", busReqP, (c != 2) && (c != 3));
            chk1("limit_if_gnt", ifGntP, (c != 2) && (c != 3));
            chk1("limit_if_rv", ifRvalidP, c == 3);
            $display("txn limit cycle %0d bus_req=%0b", c, busReqP);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            setIdle();
            busRvalid = 1'b1;
            #2;
            chk1("limit_drain_rv", ifRvalidP, 1'b1);
        end

        // Unsolicited response
        @(negedge clk);
        setIdle();
        busRvalid = 1'b1; busRdata = 32'h77;
        #2;
        chk1("perr_no_if_rv", ifRvalidP, 1'b0);
        chk1("perr_no_dm_rv", dmRvalidP, 1'b0);
        chk1("perr_not_yet", protoErrP, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            setIdle();
            #2;
            chk1("perr_sticky", protoErrP, 1'b1);
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk1("perr_cleared", protoErrP, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        $display("txn protocol error raised and cleared");

        // Randomized traffic against the reference model
        ownerQ.delete();
        waitValid = 1'b0; waitOwner = 1'b0;
        pendIf = 1'b0; pendDm = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!pendIf && $urandom_range(0, 2) == 0) begin
                pendIf = 1'b1; ifAddr = $urandom;
            end
            if (!pendDm && $urandom_range(0, 2) == 0) begin
                pendDm = 1'b1; dmAddr = $urandom; dmWe = 1'($urandom_range(0, 1));
                dmBe = 4'($urandom_range(0, 15)); dmWdata = $urandom;
            end
            ifReq = pendIf;
            dmReq = pendDm;
            busGnt = ($urandom_range(0, 3) != 0);
            busRvalid = (ownerQ.size() > 0) && ($urandom_range(0, 1) == 1);
            busRdata = $urandom;
            #2;
            sel = waitValid ? waitOwner : pendDm;
            expReq = (sel ? pendDm : pendIf) && (ownerQ.size() < 2);
            expIfGnt = expReq && busGnt && !sel;
            expDmGnt = expReq && busGnt && sel;
            expIfRv = busRvalid && (ownerQ.size() > 0) && !ownerQ[0];
            expDmRv = busRvalid && (ownerQ.size() > 0) && ownerQ[0];
            chk1("rand_bus_req", busReqP, expReq);
            chk1("rand_if_gnt", ifGntP, expIfGnt);
            chk1("rand_dm_gnt", dmGntP, expDmGnt);
            chk1("rand_if_rv", ifRvalidP, expIfRv);
            chk1("rand_dm_rv", dmRvalidP, expDmRv);
            chk1("rand_proto_err", protoErrP, 1'b0);
            if (expReq) begin
                chk32("rand_addr", busAddrP, sel ? dmAddr : ifAddr);
                chk1("rand_we", busWeP, sel ? dmWe : 1'b0);
                chk32("rand_be", {28'd0, busBeP}, sel ? {28'd0, dmBe} : 32'hF);
                chk32("rand_wdata", busWdataP, sel ? dmWdata : 32'h0);
            end
            if (busRvalid) begin
                chk32("rand_rdata", expIfRv ? ifRdataP : dmRdataP, busRdata);
            end
            $display("txn rand %0d sel=%0d req=%0b gnt=%0b rv=%0b q=%0d",
                     n, sel, busReqP, busGnt, busRvalid, ownerQ.size());
            if (busRvalid && ownerQ.size() > 0) begin
                void'(ownerQ.pop_front());
            end
            if (expReq && !busGnt) begin
                waitValid = 1'b1; waitOwner = sel;
            end else if (expReq && busGnt) begin
                waitValid = 1'b0;
                ownerQ.push_back(sel);
                if (sel) pendDm = 1'b0;
                else     pendIf = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
